// File: rtl/sa_pe_dbuf_if.sv
// Bundled handshake/data signals of one double-buffered systolic PE (west/north inputs, east/south outputs).
// slave = PE side, master = the neighbour or bench that feeds it.
interface sa_pe_dbuf_if #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 32,
    parameter int NUM_WEIGHTS   = 4
);
    localparam int WSEL_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

    logic                     i_load_valid;
    logic [WSEL_W-1:0]        i_load_slot;
    logic [MUL_DATAWIDTH-1:0] i_weight;
    logic                     i_swap;
    logic                     i_act_valid;
    logic [MUL_DATAWIDTH-1:0] i_act;
    logic [WSEL_W-1:0]        i_wsel;
    logic [ADD_DATAWIDTH-1:0] i_psum;
    logic                     i_clr_ovf;

    logic                     o_load_valid;
    logic [WSEL_W-1:0]        o_load_slot;
    logic [MUL_DATAWIDTH-1:0] o_weight;
    logic                     o_swap;
    logic                     o_act_valid;
    logic [MUL_DATAWIDTH-1:0] o_act;
    logic [WSEL_W-1:0]        o_wsel;
    logic                     o_psum_valid;
    logic [ADD_DATAWIDTH-1:0] o_psum;
    logic                     o_ovf;

    modport slave (
        input  i_load_valid, i_load_slot, i_weight, i_swap,
        input  i_act_valid, i_act, i_wsel, i_psum, i_clr_ovf,
        output o_load_valid, o_load_slot, o_weight, o_swap,
        output o_act_valid, o_act, o_wsel, o_psum_valid, o_psum, o_ovf
    );

    modport master (
        output i_load_valid, i_load_slot, i_weight, i_swap,
        output i_act_valid, i_act, i_wsel, i_psum, i_clr_ovf,
        input  o_load_valid, o_load_slot, o_weight, o_swap,
        input  o_act_valid, o_act, o_wsel, o_psum_valid, o_psum, o_ovf
    );
endinterface

// File: rtl/sa_pe_dbuf.sv
// Systolic PE with shadow/active weight banks; SA_PE_SAT_EN selects saturating add + sticky o_ovf.
// Latency: 1 cycle for MAC result and for load/swap/activation forwarding; 1 MAC per cycle.
// Backpressure: none -- valid-only flow, every valid input is consumed on the edge it is seen.
module sa_pe_dbuf #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 32,
    parameter int NUM_WEIGHTS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sa_pe_dbuf_if.slave      pe
);
    localparam int WSEL_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
    localparam int PROD_W = 2 * MUL_DATAWIDTH;

    generate
        if (ADD_DATAWIDTH < PROD_W) begin : g_bad_add_width
            $error("sa_pe_dbuf: ADD_DATAWIDTH must be >= 2*MUL_DATAWIDTH");
        end
        if (NUM_WEIGHTS < 1) begin : g_bad_num_weights
            $error("sa_pe_dbuf: NUM_WEIGHTS must be >= 1");
        end
    endgenerate

    logic signed [MUL_DATAWIDTH-1:0] shadow [NUM_WEIGHTS];
    logic signed [MUL_DATAWIDTH-1:0] active [NUM_WEIGHTS];

    logic signed [MUL_DATAWIDTH-1:0] act_s;
    logic signed [MUL_DATAWIDTH-1:0] w_rd;
    logic signed [PROD_W-1:0]        prod;
    logic signed [ADD_DATAWIDTH-1:0] prod_ext;
    logic [ADD_DATAWIDTH-1:0]        sum_res;
    logic                            load_in_range;
    logic                            wsel_in_range;

    assign act_s         = pe.i_act;
    assign load_in_range = (32'(pe.i_load_slot) < NUM_WEIGHTS);
    assign wsel_in_range = (32'(pe.i_wsel) < NUM_WEIGHTS);

`ifdef SA_PE_SAT_EN
    logic [ADD_DATAWIDTH:0] sum_wide;
    logic                   clamp;
    logic                   ovf_q;
`endif

    // Read port sees the active bank as it stood before the edge; out-of-range selects read zero.
    always_comb begin
        w_rd     = '0;
        prod     = '0;
        prod_ext = '0;
        sum_res  = '0;
`ifdef SA_PE_SAT_EN
        sum_wide = '0;
        clamp    = 1'b0;
`endif
        if (wsel_in_range) begin
            w_rd = active[pe.i_wsel];
        end
        prod     = PROD_W'(act_s) * PROD_W'(w_rd);
        prod_ext = ADD_DATAWIDTH'(prod);
`ifdef SA_PE_SAT_EN
        sum_wide = {pe.i_psum[ADD_DATAWIDTH-1], pe.i_psum}
                 + {prod_ext[ADD_DATAWIDTH-1], prod_ext};
        clamp    = sum_wide[ADD_DATAWIDTH] ^ sum_wide[ADD_DATAWIDTH-1];
        if (clamp) begin
            sum_res = sum_wide[ADD_DATAWIDTH] ? {1'b1, {(ADD_DATAWIDTH-1){1'b0}}}
                                              : {1'b0, {(ADD_DATAWIDTH-1){1'b1}}};
        end else begin
            sum_res = sum_wide[ADD_DATAWIDTH-1:0];
        end
`else
        sum_res  = pe.i_psum + prod_ext;
`endif
    end

    // Vertical path: load/swap forwarding plus the double-buffered weight banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.o_load_valid <= 1'b0;
            pe.o_load_slot  <= '0;
            pe.o_weight     <= '0;
            pe.o_swap       <= 1'b0;
            for (int k = 0; k < NUM_WEIGHTS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            pe.o_load_valid <= pe.i_load_valid;
            pe.o_swap       <= pe.i_swap;
            if (pe.i_load_valid) begin
                pe.o_load_slot <= pe.i_load_slot;
                pe.o_weight    <= pe.i_weight;
            end
            // NBA semantics make a same-edge write land in shadow only, after the copy.
            if (pe.i_swap) begin
                for (int k = 0; k < NUM_WEIGHTS; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (pe.i_load_valid && load_in_range) begin
                shadow[pe.i_load_slot] <= pe.i_weight;
            end
        end
    end

    // Horizontal path: MAC result and activation forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.o_act_valid  <= 1'b0;
            pe.o_act        <= '0;
            pe.o_wsel       <= '0;
            pe.o_psum_valid <= 1'b0;
            pe.o_psum       <= '0;
        end else begin
            pe.o_act_valid  <= pe.i_act_valid;
            pe.o_psum_valid <= pe.i_act_valid;
            if (pe.i_act_valid) begin
                pe.o_act  <= pe.i_act;
                pe.o_wsel <= pe.i_wsel;
                pe.o_psum <= sum_res;
            end
        end
    end

`ifdef SA_PE_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (pe.i_clr_ovf) begin
            ovf_q <= 1'b0;
        end else if (pe.i_act_valid && clamp) begin
            ovf_q <= 1'b1;
        end
    end
    assign pe.o_ovf = ovf_q;
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = pe.i_clr_ovf;
    assign pe.o_ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_sa_pe_dbuf.sv
// Bench for sa_pe_dbuf: directed plan cases then random traffic, all checked against an integer reference model.
module tb_sa_pe_dbuf;
    localparam int MW = 8;
    localparam int AW = 32;
    localparam int NW = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sa_pe_dbuf_if #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW), .NUM_WEIGHTS(NW)) bus ();

    sa_pe_dbuf #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW), .NUM_WEIGHTS(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pe    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: weights as plain integers, outputs as expected values.
    int          m_sh [NW];
    int          m_ac [NW];
    logic        m_lv, m_swp, m_av, m_pv, m_ovf;
    logic [1:0]  m_slot, m_wsel;
    logic [7:0]  m_weight, m_act;
    logic [31:0] m_psum;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NW; k++) begin
            m_sh[k] = 0;
            m_ac[k] = 0;
        end
        m_lv = 0; m_swp = 0; m_av = 0; m_pv = 0; m_ovf = 0;
        m_slot = 0; m_wsel = 0; m_weight = 0; m_act = 0; m_psum = 0;
    endtask

    task automatic model_edge();
        longint s;
        logic   clamped;
        int     w;
        clamped = 0;
        if (bus.i_act_valid) begin
            w = (int'(bus.i_wsel) < NW) ? m_ac[bus.i_wsel] : 0;
            s = longint'($signed(bus.i_psum)) + longint'(int'($signed(bus.i_act)) * w);
`ifdef SA_PE_SAT_EN
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647;
                clamped = 1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648;
                clamped = 1;
            end
`endif
            m_psum = 32'(s);
            m_act  = bus.i_act;
            m_wsel = bus.i_wsel;
        end
        m_av = bus.i_act_valid;
        m_pv = bus.i_act_valid;
`ifdef SA_PE_SAT_EN
        if (bus.i_clr_ovf) m_ovf = 0;
        else if (bus.i_act_valid && clamped) m_ovf = 1;
`else
        m_ovf = 0;
`endif
        m_lv  = bus.i_load_valid;
        m_swp = bus.i_swap;
        if (bus.i_load_valid) begin
            m_weight = bus.i_weight;
            m_slot   = bus.i_load_slot;
        end
        if (bus.i_swap) m_ac = m_sh;
        if (bus.i_load_valid && int'(bus.i_load_slot) < NW)
            m_sh[bus.i_load_slot] = int'($signed(bus.i_weight));
    endtask

    task automatic compare_all();
        check("o_load_valid", bus.o_load_valid, m_lv);
        check("o_load_slot",  bus.o_load_slot,  m_slot);
        check("o_weight",     bus.o_weight,     m_weight);
        check("o_swap",       bus.o_swap,       m_swp);
        check("o_act_valid",  bus.o_act_valid,  m_av);
        check("o_act",        bus.o_act,        m_act);
        check("o_wsel",       bus.o_wsel,       m_wsel);
        check("o_psum_valid", bus.o_psum_valid, m_pv);
        check("o_psum",       bus.o_psum,       m_psum);
        check("o_ovf",        bus.o_ovf,        m_ovf);
    endtask

    task automatic drive(input logic lv, input logic [1:0] slot, input logic [7:0] wt, input logic swp,
                         input logic av, input logic [7:0] act, input logic [1:0] wsel,
                         input logic [31:0] psum, input logic clr);
        bus.i_load_valid = lv;
        bus.i_load_slot  = slot;
        bus.i_weight     = wt;
        bus.i_swap       = swp;
        bus.i_act_valid  = av;
        bus.i_act        = act;
        bus.i_wsel       = wsel;
        bus.i_psum       = psum;
        bus.i_clr_ovf    = clr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] ps;
        int          load_w [4];
        n_checks = 0;
        n_errors = 0;
        load_w   = '{3, -2, 5, 127};
        rst_n    = 1'b0;
        idle();
        model_reset();
        #2;
        compare_all();
        #10 rst_n = 1'b1;

        // Plan 1: load 3,-2,5,127, swap, MAC act=10 wsel=2 psum=100 -> 150.
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k), 8'(load_w[k]), 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 8'd10, 2'd2, 32'd100, 0); step();
        check("t1_psum", bus.o_psum, 32'd150);
        check("t1_psum_valid", bus.o_psum_valid, 1'b1);
        check("t1_act", bus.o_act, 8'd10);
        check("t1_wsel", bus.o_wsel, 2'd2);

        // Plan 2: shadow write without swap stays invisible.
        drive(1, 2'd1, 8'd7, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 8'd4, 2'd1, 32'd0, 0); step();
        check("t2_before_swap", bus.o_psum, 32'hFFFF_FFF8);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 8'd4, 2'd1, 32'd0, 0); step();
        check("t2_after_swap", bus.o_psum, 32'd28);

        // Plan 3: swap + load + MAC on the same edge.
        drive(1, 2'd0, 8'd9, 1, 1, 8'd1, 2'd0, 32'd0, 0); step();
        check("t3_same_edge", bus.o_psum, 32'd3);
        drive(0, 0, 0, 0, 1, 8'd1, 2'd0, 32'd0, 0); step();
        check("t3_next_mac", bus.o_psum, 32'd3);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 8'd1, 2'd0, 32'd0, 0); step();
        check("t3_after_swap", bus.o_psum, 32'd9);

        // Plan 4: load/swap forwarding and weight hold.
        drive(1, 2'd2, 8'h55, 1, 0, 0, 0, 0, 0); step();
        check("t4_weight", bus.o_weight, 8'h55);
        check("t4_slot", bus.o_load_slot, 2'd2);
        check("t4_swap", bus.o_swap, 1'b1);
        idle(); step();
        check("t4_lv_drop", bus.o_load_valid, 1'b0);
        check("t4_weight_hold", bus.o_weight, 8'h55);

        // Plan 5: overflow boundary on slot 3 (=127).
        drive(0, 0, 0, 0, 1, 8'd127, 2'd3, 32'h7FFF_FFF0, 0); step();
`ifdef SA_PE_SAT_EN
        check("t5_sat_psum", bus.o_psum, 32'h7FFF_FFFF);
        check("t5_ovf_set", bus.o_ovf, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        check("t5_ovf_clr", bus.o_ovf, 1'b0);
`else
        check("t5_wrap_psum", bus.o_psum, 32'h8000_3EF1);
        check("t5_ovf_zero", bus.o_ovf, 1'b0);
`endif

        // Plan 6: asynchronous reset mid-stream.
        drive(0, 0, 0, 0, 1, 8'd3, 2'd3, 32'd77, 0); step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("t6_psum_zero", bus.o_psum, 32'd0);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 8'd5, 2'd0, 32'd42, 0); step();
        check("t6_banks_cleared", bus.o_psum, 32'd42);

        // Random traffic, psum biased towards the overflow boundaries.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       ps = 32'h7FFF_C000 + $urandom_range(0, 32'h3FFF);
                1:       ps = 32'h8000_0000 + $urandom_range(0, 32'h3FFF);
                default: ps = $urandom;
            endcase
            drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), ps,
                  1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
